// File: rtl/bocks_video_pkg.sv
// Shared types and constants for the bocks test-pattern video generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bocks_video_pkg;

  typedef enum logic [1:0] {
    MODE_CHECKER = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_PALETTE = 2'd3
  } mode_e;

  // 640x480 @ 60 Hz style default timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int PAL_DEPTH = 16;
  localparam int PAL_AW    = $clog2(PAL_DEPTH);
  localparam int PAL_BYTES = PAL_DEPTH * 3;

  // Element [0] is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][23:0] BAR_COLOURS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return BAR_COLOURS[idx];
  endfunction

endpackage

// File: rtl/bocks_palette.sv
// 16-entry x 24-bit palette with a flat byte-write port (3 bytes per entry, R/G/B).
// Latency: write lands on the clock edge; read is combinational from the stored entries.
// Backpressure: none; writes are always accepted, addresses beyond the table are dropped.
module bocks_palette
  import bocks_video_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [26:0]       addr_i,
  input  logic [7:0]        dat_i,
  input  logic [PAL_AW-1:0] rd_idx_i,
  output logic [23:0]       rd_dat_o
);

  logic [23:0]       pal_q [PAL_DEPTH];
  logic              wr_hit;
  logic [5:0]        wr_byte;
  logic [PAL_AW-1:0] wr_entry;
  logic [1:0]        wr_comp;

  // Decode the flat byte address into entry index and colour component.
  always_comb begin
    wr_byte  = addr_i[5:0];
    wr_hit   = wr_i && (addr_i < 27'(PAL_BYTES));
    wr_entry = 4'(wr_byte / 6'd3);
    wr_comp  = 2'(wr_byte % 6'd3);
  end

  // Register file: cleared by reset, one byte lane written per cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < PAL_DEPTH; i++) pal_q[i] <= '0;
    end else if (wr_hit) begin
      case (wr_comp)
        2'd0:    pal_q[wr_entry][23:16] <= dat_i;
        2'd1:    pal_q[wr_entry][15:8]  <= dat_i;
        default: pal_q[wr_entry][7:0]   <= dat_i;
      endcase
    end
  end

  // Reading the stored array means a same-cycle write is seen one cycle later.
  assign rd_dat_o = pal_q[rd_idx_i];

endmodule

// File: rtl/bocks_video_gen.sv
// Video timing + test-pattern generator (checker, bars, solid, palette cells).
// Latency: every output is registered one ce_pix after the h/v counters it reflects.
// Backpressure: none; ce_pix=0 freezes counters and outputs, palette writes still land.
module bocks_video_gen
  import bocks_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,  // must be a multiple of 8 for the bars
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int SQ_LOG2  = 5
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [1:0]  mode,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        hblank,
  output logic        vblank,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
);

  localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_W = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_W = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W   = 12'(H_ACTIVE / 8);

  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  mode_e       mode_q, mode_eff;
  logic        frame_first, h_act, v_act, in_hs, in_vs;
  logic [11:0] cell_x, cell_y;
  logic [2:0]  bar_idx;
  logic [3:0]  pal_rd_idx;
  logic [23:0] pal_rd_dat, pix_rgb;

  logic        hs_q, vs_q, de_q, hblank_q, vblank_q, fs_q;
  logic [23:0] rgb_q;
  logic [11:0] x_q, y_q;

  bocks_palette u_palette (
    .clk_i    (pclk),
    .rst_ni   (reset_n),
    .wr_i     (ioctl_wr),
    .addr_i   (ioctl_addr),
    .dat_i    (ioctl_dout),
    .rd_idx_i (pal_rd_idx),
    .rd_dat_o (pal_rd_dat)
  );

  // Counter advance, region decode and pattern colour for the pixel at (h_cnt, v_cnt).
  always_comb begin
    frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);
    // Pixel (0,0) already uses the freshly sampled mode so a whole frame shares one mode.
    mode_eff    = frame_first ? mode_e'(mode) : mode_q;
    h_act       = h_cnt_q < H_ACT_W;
    v_act       = v_cnt_q < V_ACT_W;
    in_hs       = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    in_vs       = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    cell_x      = h_cnt_q >> SQ_LOG2;
    cell_y      = v_cnt_q >> SQ_LOG2;
    bar_idx     = 3'(h_cnt_q / BAR_W);
    pal_rd_idx  = (mode_eff == MODE_SOLID) ? 4'd0 : 4'(cell_x + cell_y);

    case (mode_eff)
      MODE_CHECKER: pix_rgb = (cell_x[0] ^ cell_y[0]) ? 24'h000000 : 24'hFFFFFF;
      MODE_BARS:    pix_rgb = bar_colour(bar_idx);
      default:      pix_rgb = pal_rd_dat;
    endcase

    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
  end

  // Raster counters and per-frame mode latch.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= MODE_CHECKER;
    end else if (ce_pix) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (frame_first) mode_q <= mode_e'(mode);
    end
  end

  // Output register stage: all video outputs move together on ce_pix.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      rgb_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
    end else if (ce_pix) begin
      hs_q     <= in_hs ? HS_POL : ~HS_POL;
      vs_q     <= in_vs ? VS_POL : ~VS_POL;
      de_q     <= h_act && v_act;
      hblank_q <= !h_act;
      vblank_q <= !v_act;
      rgb_q    <= (h_act && v_act) ? pix_rgb : 24'h000000;
      x_q      <= h_cnt_q;
      y_q      <= v_cnt_q;
      fs_q     <= frame_first;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_bocks_video_gen.sv
// Self-checking bench for bocks_video_gen on a scaled-down raster (96x50 total).
// Reference: pixel index arithmetic, per-frame mode latch and a palette array.
// Inputs change between edges; outputs are sampled 1 ns after each rising edge.
module tb_bocks_video_gen;

  localparam int H_ACT = 64, H_FP = 8, H_SYN = 12, H_BP = 12;
  localparam int V_ACT = 40, V_FP = 2, V_SYN = 3, V_BP = 5;
  localparam int SQ    = 3;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b0;
  localparam int H_T = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_T = V_ACT + V_FP + V_SYN + V_BP;
  localparam int F_T = H_T * V_T;
  localparam logic [53:0] RST_V = {!HS_POL, !VS_POL, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 12'h0, 12'h0};

  logic        pclk = 1'b0;
  logic        reset_n, ce_pix, ioctl_wr;
  logic [1:0]  mode;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        hs, vs, de, hblank, vblank, frame_start;
  logic [7:0]  r, g, b;
  logic [11:0] x, y;

  always #5 pclk = ~pclk;

  bocks_video_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .SQ_LOG2(SQ)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .ce_pix(ce_pix), .mode(mode),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .hs(hs), .vs(vs), .de(de), .hblank(hblank), .vblank(vblank),
    .r(r), .g(g), .b(b), .x(x), .y(y), .frame_start(frame_start)
  );

  // Reference model state
  int          p;          // index of the next pixel the raster will process
  int          fmode;      // mode in force for the current frame
  logic [23:0] pal [16];
  logic [53:0] exp_v;
  int          last_h, last_v;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Bookkeeping and measurements
  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int hs_fall_cyc = -1, hs_period = 0, fs_cyc = -1, fs_period = 0;
  int de_run = 0, good_runs = 0, bad_runs = 0;
  bit prev_hs = 1'b1, prev_fs = 1'b0, pal_px_en = 1'b0, last_ce = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [53:0] model_pix(input int h, input int v, input int md);
    logic [23:0] c;
    bit act, hsy, vsy;
    act = (h < H_ACT) && (v < V_ACT);
    hsy = (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYN) ? HS_POL : !HS_POL;
    vsy = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYN) ? VS_POL : !VS_POL;
    c = 24'h0;
    if (act) begin
      case (md)
        0:       c = ((((h >> SQ) ^ (v >> SQ)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
        1:       c = bars[h / (H_ACT / 8)];
        2:       c = pal[0];
        default: c = pal[((h >> SQ) + (v >> SQ)) % 16];
      endcase
    end
    return {hsy, vsy, act, !(h < H_ACT), !(v < V_ACT), (h == 0 && v == 0), c, 12'(h), 12'(v)};
  endfunction

  // One clock: drive inputs, advance the model at the edge, then compare everything.
  task automatic step(input bit ce, input bit rn, input logic [1:0] md,
                      input bit wr, input int addr, input logic [7:0] dat);
    logic [53:0] act;
    ce_pix = ce; reset_n = rn; mode = md;
    ioctl_wr = wr; ioctl_addr = 27'(addr); ioctl_dout = dat;
    @(posedge pclk);
    last_ce = ce && rn;
    if (!rn) begin
      p = 0; fmode = 0; exp_v = RST_V;
      for (int i = 0; i < 16; i++) pal[i] = 24'h0;
    end else begin
      if (ce) begin
        last_h = p % H_T;
        last_v = p / H_T;
        if (p == 0) fmode = md;
        exp_v = model_pix(last_h, last_v, fmode);
        p = (p + 1) % F_T;
      end
      if (wr && addr < 48) pal[addr / 3][23 - 8 * (addr % 3) -: 8] = dat;
    end
    #1;
    cyc++;
    act = {hs, vs, de, hblank, vblank, frame_start, r, g, b, x, y};
    chk("outs", 64'(act), 64'(exp_v));
    if (pal_px_en && last_ce && last_h == 8 && last_v == 0) chk("pal_px", 64'({r, g, b}), 64'h123456);
    if (prev_hs && !hs) begin
      if (hs_fall_cyc >= 0) hs_period = cyc - hs_fall_cyc;
      hs_fall_cyc = cyc;
    end
    prev_hs = hs;
    if (!prev_fs && frame_start) begin
      if (fs_cyc >= 0) fs_period = cyc - fs_cyc;
      fs_cyc = cyc;
    end
    prev_fs = frame_start;
    if (de) de_run++;
    else begin
      if (de_run == H_ACT) good_runs++;
      else if (de_run != 0) bad_runs++;
      de_run = 0;
    end
  endtask

  task automatic run_until(input int target, input logic [1:0] md);
    int i = 0;
    while (p != target && i <= F_T) begin
      step(1'b1, 1'b1, md, 1'b0, 0, 8'h0);
      i++;
    end
    if (p != target) chk("bound", 64'(p), 64'(target));
  endtask

  initial begin
    logic [1:0] md;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, 1'b0, 0, 8'h0);
    chk("rst_de", 64'(de), 64'd0);

    // Full frame, ce_pix every clock, checkerboard: timing measurements
    good_runs = 0; bad_runs = 0; de_run = 0;
    for (int i = 0; i < F_T + 20; i++) step(1'b1, 1'b1, 2'd0, 1'b0, 0, 8'h0);
    chk("line_period", 64'(hs_period), 64'(H_T));
    chk("frame_period", 64'(fs_period), 64'(F_T));
    chk("de_lines", 64'(good_runs), 64'(V_ACT));
    chk("de_bad_runs", 64'(bad_runs), 64'd0);

    // Palette writes with ce_pix low, including an out-of-range address
    step(1'b0, 1'b1, 2'd3, 1'b1, 3, 8'h12);
    step(1'b0, 1'b1, 2'd3, 1'b1, 4, 8'h34);
    step(1'b0, 1'b1, 2'd3, 1'b1, 5, 8'h56);
    step(1'b0, 1'b1, 2'd3, 1'b1, 48, 8'hAA);
    run_until(0, 2'd3);
    pal_px_en = 1'b1;
    for (int i = 0; i < F_T; i++) step(1'b1, 1'b1, 2'd3, 1'b0, 0, 8'h0);
    pal_px_en = 1'b0;

    // Random ce_pix, random palette traffic, occasional mid-frame mode changes
    md = 2'd3;
    for (int i = 0; i < 2 * F_T; i++) begin
      if ($urandom_range(299) == 0) md = 2'($urandom_range(3));
      step($urandom_range(3) != 0, 1'b1, md, $urandom_range(3) == 0,
           int'($urandom_range(63)), 8'($urandom));
    end

    // Mode 0 -> 1 change at line 20 takes effect only at the next frame
    run_until(0, 2'd0);
    run_until(20 * H_T, 2'd0);
    run_until(0, 2'd1);
    for (int i = 0; i < 2 * H_T; i++) step(1'b1, 1'b1, 2'd1, 1'b0, 0, 8'h0);

    // ce_pix on one clock in two: line period doubles
    for (int i = 0; i < 8 * H_T; i++) step((i % 2) == 0, 1'b1, 2'd1, 1'b0, 0, 8'h0);
    chk("line_period_half", 64'(hs_period), 64'(2 * H_T));

    // One-clock reset mid-frame, then restart at pixel (0,0)
    run_until(20 * H_T + 30, 2'd1);
    step(1'b0, 1'b0, 2'd1, 1'b0, 0, 8'h0);
    chk("rst_mid_de", 64'(de), 64'd0);
    chk("rst_mid_rgb", 64'({r, g, b}), 64'd0);
    chk("rst_mid_hs", 64'(hs), 64'(!HS_POL));
    chk("rst_mid_vs", 64'(vs), 64'(!VS_POL));
    step(1'b0, 1'b1, 2'd0, 1'b0, 0, 8'h0);
    step(1'b0, 1'b1, 2'd0, 1'b0, 0, 8'h0);
    chk("rst_hold_fs", 64'(frame_start), 64'd0);
    step(1'b1, 1'b1, 2'd0, 1'b0, 0, 8'h0);
    chk("rst_first_fs", 64'(frame_start), 64'd1);
    chk("rst_first_xy", 64'({x, y}), 64'd0);
    for (int i = 0; i < 2 * H_T; i++) step(1'b1, 1'b1, 2'd0, 1'b0, 0, 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
